// File: rtl/dbf_scan_ctrl.sv
// Per-scan-line sequencer for the DBF channel array: LUT load, TX window, dead gap, RX window.
// Optional sticky overlapping-request flag req_err is enabled by defining DBF_SCAN_ERR_EN.
module dbf_scan_ctrl #(
    parameter int ADDR_WD   = 6,
    parameter int LUT_DEPTH = 64,
    parameter int TX_LEN    = 16,
    parameter int DEAD_LEN  = 8,
    parameter int RX_LEN    = 1024,
    parameter int NUM_LINES = 128,
    parameter int LINE_WD   = 7,
    parameter int CNT_WD    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_req,
    input  logic               abort,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               tx_en,
    output logic               start,
    output logic [LINE_WD-1:0] line_idx,
    output logic               busy,
    output logic               line_done,
`ifdef DBF_SCAN_ERR_EN
    output logic               req_err,
`endif
    output logic               frame_done
);

    typedef enum logic [2:0] {IDLE, LOAD, TX, GAP, RX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic [LINE_WD-1:0] line_q, line_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic               we_q, we_d, tx_q, tx_d, start_q, start_d;
    logic               busy_q, busy_d, done_q, done_d, frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_WD'(1);
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (line_req && !abort) state_d = LOAD;
            end
            LOAD: if (cnt_q == CNT_WD'(LUT_DEPTH - 1)) begin
                cnt_d   = '0;
                state_d = TX;
            end
            TX: if (cnt_q == CNT_WD'(TX_LEN - 1)) begin
                cnt_d   = '0;
                state_d = (DEAD_LEN == 0) ? RX : GAP;
            end
            GAP: if (cnt_q == CNT_WD'(DEAD_LEN - 1)) begin
                cnt_d   = '0;
                state_d = RX;
            end
            RX: if (cnt_q == CNT_WD'(RX_LEN - 1)) begin
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
                line_d  = (line_q == LINE_WD'(NUM_LINES - 1)) ? '0 : line_q + LINE_WD'(1);
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Abort cancels the line without advancing the line index.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            line_d  = line_q;
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        we_d    = (state_d == LOAD);
        addr_d  = we_d ? ADDR_WD'(cnt_d) : '0;
        tx_d    = (state_d == TX);
        start_d = (state_d == RX);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        frame_d = done_d && (line_q == LINE_WD'(NUM_LINES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            tx_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            frame_q <= frame_d;
        end
    end

`ifdef DBF_SCAN_ERR_EN
    logic req_err_q, req_err_d;

    always_comb begin
        req_err_d = abort ? 1'b0 : (req_err_q | (line_req & busy_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_err_q <= 1'b0;
        else        req_err_q <= req_err_d;
    end

    assign req_err = req_err_q;
`endif

    assign dbf_lut_addr = addr_q;
    assign dbf_lut_we   = we_q;
    assign tx_en        = tx_q;
    assign start        = start_q;
    assign line_idx     = line_q;
    assign busy         = busy_q;
    assign line_done    = done_q;
    assign frame_done   = frame_q;

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Bench for dbf_scan_ctrl: two instances (dead gap 1 and 0) checked every cycle against a
// timeline model that derives all strobes from the cycle offset since the line request.
module tb_dbf_scan_ctrl;

    localparam int L = 4, T = 2, R = 3, NL = 3;
    localparam int DL [2] = '{1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_req = 1'b0;
    logic abort = 1'b0;

    logic [1:0]      we_w, tx_w, st_w, busy_w, done_w, fd_w, err_w;
    logic [1:0][1:0] addr_w, line_w;

    int checks = 0;
    int errors = 0;

    // Model: per instance, active flag, cycle offset t (1 = first LUT write), line, sticky error.
    bit ma [2];
    int mt [2];
    int mline [2];
    bit merr [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dbf_scan_ctrl #(
            .ADDR_WD(2), .LUT_DEPTH(L), .TX_LEN(T), .DEAD_LEN(DL[g]), .RX_LEN(R),
            .NUM_LINES(NL), .LINE_WD(2), .CNT_WD(8)
        ) dut (
            .clk(clk), .rst_n(rst_n), .line_req(line_req), .abort(abort),
            .dbf_lut_addr(addr_w[g]), .dbf_lut_we(we_w[g]), .tx_en(tx_w[g]), .start(st_w[g]),
            .line_idx(line_w[g]), .busy(busy_w[g]), .line_done(done_w[g]),
`ifdef DBF_SCAN_ERR_EN
            .req_err(err_w[g]),
`endif
            .frame_done(fd_w[g])
        );
`ifndef DBF_SCAN_ERR_EN
        assign err_w[g] = 1'b0;
`endif
    end

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ma[i] = 0; mt[i] = 0; mline[i] = 0; merr[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int d, t, total;
            bit we, tx, st, dn;
            d     = DL[i];
            t     = ma[i] ? mt[i] : 0;
            total = L + T + d + R + 1;
            we    = ma[i] && t >= 1 && t <= L;
            tx    = ma[i] && t > L && t <= L + T;
            st    = ma[i] && t > L + T + d && t <= L + T + d + R;
            dn    = ma[i] && t == total;
            chk("we", i, 32'(we_w[i]), 32'(we));
            chk("addr", i, 32'(addr_w[i]), we ? 32'(t - 1) : 32'd0);
            chk("tx_en", i, 32'(tx_w[i]), 32'(tx));
            chk("start", i, 32'(st_w[i]), 32'(st));
            chk("busy", i, 32'(busy_w[i]), 32'(ma[i]));
            chk("line_done", i, 32'(done_w[i]), 32'(dn));
            chk("frame_done", i, 32'(fd_w[i]), 32'(dn && mline[i] == NL - 1));
            chk("line_idx", i, 32'(line_w[i]), 32'(mline[i]));
`ifdef DBF_SCAN_ERR_EN
            chk("req_err", i, 32'(err_w[i]), 32'(merr[i]));
`endif
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1ns later.
    task automatic step(input bit req, input bit ab);
        line_req = req;
        abort    = ab;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int total;
            total   = L + T + DL[i] + R + 1;
            merr[i] = ab ? 1'b0 : (merr[i] | (req & ma[i]));
            if (ma[i]) begin
                if (ab) ma[i] = 0;
                else if (mt[i] == total) begin
                    ma[i] = 0;
                    mline[i] = (mline[i] + 1) % NL;
                end else mt[i]++;
            end else if (req && !ab) begin
                ma[i] = 1; mt[i] = 1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();

        // Three full lines: the third raises frame_done and wraps line_idx.
        for (int n = 0; n < 3; n++) begin
            step(1, 0);
            idle(12);
        end

        // Abort on RX cycle 2 (dead-gap instance), then replay the same line.
        step(1, 0);
        idle(8);
        step(0, 1);
        idle(3);
        step(1, 0);
        idle(12);

        // Request during TX is dropped; abort clears the error flag.
        step(1, 0);
        idle(4);
        step(1, 0);
        idle(9);
        step(0, 1);
        step(1, 1);
        idle(2);

        // Asynchronous reset while writing address 2.
        step(1, 0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        idle(4);

        // Randomised requests and aborts.
        for (int k = 0; k < 400; k++)
            step(($urandom % 8) == 0, ($urandom % 40) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbf_scan_ctrl.md
Name: dbf_scan_ctrl

Overview:
- Per-scan-line sequencer for the DBF channel array (dbf_chNN instances).
- Drives the shared coarse/fine delay LUT write bus (dbf_lut_addr / dbf_lut_we), the transmit window (tx_en) and the receive/beamform window (start).
- Steps the line index through the frame, one line per request.
- Sits between the system controller (line_req / abort) and all DBF channels; one instance fans out to every channel.

Parameters:
- ADDR_WD, 6, width of dbf_lut_addr; must satisfy 2^ADDR_WD >= LUT_DEPTH.
- LUT_DEPTH, 64, number of LUT entries written per line.
- TX_LEN, 16, tx_en high time in cycles; must be >= 1.
- DEAD_LEN, 8, idle cycles between tx_en falling and start rising; 0 allowed.
- RX_LEN, 1024, start high time in cycles; must be >= 1.
- NUM_LINES, 128, lines per frame.
- LINE_WD, 7, width of line_idx.
- CNT_WD, 16, width of the internal phase counter; must hold max(LUT_DEPTH, TX_LEN, DEAD_LEN, RX_LEN).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- line_req, input, 1, single-cycle request to run the next line.
- abort, input, 1, synchronous cancel of the current line.
- dbf_lut_addr, output, ADDR_WD, LUT write address to all channels.
- dbf_lut_we, output, 1, LUT write enable to all channels.
- tx_en, output, 1, transmit window; channels gate their input valid with ~tx_en.
- start, output, 1, receive/beamform window to all channels.
- line_idx, output, LINE_WD, index of the current/next line.
- busy, output, 1, high in any state other than IDLE.
- line_done, output, 1, one-cycle pulse at the end of a line.
- frame_done, output, 1, one-cycle pulse coincident with line_done on the last line.

Behaviour:
- Single clock. Asynchronous active-low reset on rst_n. All outputs are registered.
- Reset values:
  - All outputs are 0.
  - State is IDLE; counter is 0; line_idx is 0.
- State machine: IDLE -> LOAD -> TX -> GAP -> RX -> DONE -> IDLE.
- IDLE:
  - All strobes are 0 and dbf_lut_addr is 0.
  - line_req=1 moves to LOAD on the next edge.
- LOAD:
  - dbf_lut_we=1 for exactly LUT_DEPTH cycles.
  - dbf_lut_addr = 0, 1, …, LUT_DEPTH-1, one value per cycle.
  - The cycle after the last write is the first TX cycle.
- TX: tx_en=1 for exactly TX_LEN cycles; dbf_lut_we=0 and dbf_lut_addr=0.
- GAP:
  - All strobes are 0 for DEAD_LEN cycles.
  - If DEAD_LEN=0, GAP is skipped and start rises the cycle after tx_en falls.
- RX: start=1 for exactly RX_LEN cycles.
- DONE (one cycle):
  - line_done=1.
  - frame_done=1 if line_idx==NUM_LINES-1.
  - line_idx increments on this edge and wraps to 0 after NUM_LINES-1.
  - Next state is IDLE.
- Latency:
  - line_req to first we: 1 cycle.
  - line_req to line_done: LUT_DEPTH+TX_LEN+DEAD_LEN+RX_LEN+1 cycles.
  - A line_req in the same cycle line_done is high is ignored.
- line_req while busy: ignored and not queued.
- tx_en and start are never high in the same cycle. dbf_lut_we is never high with tx_en or start.
- abort (any non-IDLE state):
  - Next edge goes to IDLE with all strobes 0.
  - line_idx is unchanged and no line_done is issued.
  - abort in IDLE has no effect.
  - abort together with line_req in IDLE: abort wins and the line does not start.
- Reset mid-operation: all strobes drop asynchronously; line_idx returns to 0.

Optional Feature:
- Macro DBF_SCAN_ERR_EN.
- Defined:
  - Adds output req_err (1 bit, reset 0).
  - req_err is a sticky flag, set when line_req arrives while busy=1.
  - Cleared only by reset or by an abort pulse.
- Not defined: the port is absent and overlapping requests are silently dropped.

Test Plan:
- Reset then line_req, with LUT_DEPTH=4, TX_LEN=2, DEAD_LEN=1, RX_LEN=3:
  - we high with addr 0, 1, 2, 3 on cycles 1–4.
  - tx_en on cycles 5–6, gap on cycle 7, start on cycles 8–10.
  - line_done on cycle 11, line_idx then 1.
- DEAD_LEN=0 with the same settings: start rises on the cycle immediately after tx_en falls; no overlap.
- NUM_LINES=3, run 3 lines: frame_done is high only with the third line_done; line_idx reads 0 afterwards.
- abort during cycle 2 of RX: start drops on the next cycle, no line_done, line_idx unchanged. A new line_req replays the same line index.
- line_req pulsed during TX:
  - The line completes at unchanged timing and no second line runs.
  - With DBF_SCAN_ERR_EN defined, req_err=1 until abort.
- rst_n asserted mid-LOAD (addr=2): we, addr and line_idx read 0 immediately; after release, stays in IDLE until line_req.
